// File: rtl/qupls_alu_steer.sv
// In-order steering queue feeding the two integer ALUs.
// ALU #0-only work (mul/div/CSR/BSR/JSR/PRED) never reaches ALU #1; up to two dispatches per cycle.
module qupls_alu_steer #(
    parameter int  DEPTH         = 4,
    parameter int  TAGW          = 5,
    parameter type instruction_t = logic [31:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_v,
    output logic                     in_rdy,
    input  instruction_t             in_instr,
    input  logic                     in_alu0,
    input  logic [TAGW-1:0]          in_tag,
    output logic                     alu0_v,
    input  logic                     alu0_rdy,
    output instruction_t             alu0_instr,
    output logic [TAGW-1:0]          alu0_tag,
    output logic                     alu1_v,
    input  logic                     alu1_rdy,
    output instruction_t             alu1_instr,
    output logic [TAGW-1:0]          alu1_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   head_q, head_d, tail_q, tail_d, sec_ptr_s;
    logic [CW-1:0]   count_q, count_d;
    instruction_t    instr_mem_q [DEPTH];
    logic [TAGW-1:0] tag_mem_q   [DEPTH];
    logic [DEPTH-1:0] alu0_mem_q;

    logic       push_s, has_h_s, has_s_s, h_alu0_s, s_alu0_s;
    logic       h_to0_s, h_to1_s, s_to0_s, s_to1_s;
    logic [1:0] pops_s;

    // in_rdy looks only at the registered occupancy, so a same-cycle pop never opens a slot
    assign in_rdy = (count_q < CW'(DEPTH));
    assign count  = count_q;
    assign push_s = in_v & in_rdy;

    // Steering decision for the head and second entries
    always_comb begin
        sec_ptr_s = head_q + AW'(1);
        has_h_s   = (count_q != {CW{1'b0}});
        has_s_s   = (count_q > CW'(1));
        h_alu0_s  = alu0_mem_q[head_q];
        s_alu0_s  = alu0_mem_q[sec_ptr_s];
        h_to1_s   = has_h_s & ~h_alu0_s & alu1_rdy;
        h_to0_s   = has_h_s & alu0_rdy & (h_alu0_s | ~alu1_rdy);
        s_to1_s   = has_s_s & h_to0_s & ~s_alu0_s & alu1_rdy;
        s_to0_s   = has_s_s & h_to1_s & alu0_rdy;
    end

    // ALU #0 port mux; data is zero whenever the valid is low
    always_comb begin
        alu0_v = h_to0_s | s_to0_s;
        if (h_to0_s) begin
            alu0_instr = instr_mem_q[head_q];
            alu0_tag   = tag_mem_q[head_q];
        end else if (s_to0_s) begin
            alu0_instr = instr_mem_q[sec_ptr_s];
            alu0_tag   = tag_mem_q[sec_ptr_s];
        end else begin
            alu0_instr = '0;
            alu0_tag   = {TAGW{1'b0}};
        end
    end

    // ALU #1 port mux; data is zero whenever the valid is low
    always_comb begin
        alu1_v = h_to1_s | s_to1_s;
        if (h_to1_s) begin
            alu1_instr = instr_mem_q[head_q];
            alu1_tag   = tag_mem_q[head_q];
        end else if (s_to1_s) begin
            alu1_instr = instr_mem_q[sec_ptr_s];
            alu1_tag   = tag_mem_q[sec_ptr_s];
        end else begin
            alu1_instr = '0;
            alu1_tag   = {TAGW{1'b0}};
        end
    end

    // Pointer and occupancy next state; flush discards any same-cycle push or dispatch
    always_comb begin
        pops_s = {1'b0, alu0_v} + {1'b0, alu1_v};
        if (flush) begin
            head_d  = {AW{1'b0}};
            tail_d  = {AW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            head_d  = head_q + AW'(pops_s);
            tail_d  = tail_q + AW'(push_s);
            count_d = count_q + CW'(push_s) - CW'(pops_s);
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset is applied
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            instr_mem_q[tail_q] <= in_instr;
            tag_mem_q[tail_q]   <= in_tag;
            alu0_mem_q[tail_q]  <= in_alu0;
        end else begin
            alu0_mem_q <= alu0_mem_q;
        end
    end

endmodule

// File: tb/tb_qupls_alu_steer.sv
// Self-checking bench for qupls_alu_steer: queue-based reference model plus directed and random stimulus.
module tb_qupls_alu_steer;

    localparam int DEPTH = 4;
    localparam int TAGW  = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_v = 1'b0;
    logic            in_rdy;
    logic [31:0]     in_instr = 32'd0;
    logic            in_alu0 = 1'b0;
    logic [TAGW-1:0] in_tag = 5'd0;
    logic            alu0_v, alu1_v;
    logic            alu0_rdy = 1'b0;
    logic            alu1_rdy = 1'b0;
    logic [31:0]     alu0_instr, alu1_instr;
    logic [TAGW-1:0] alu0_tag, alu1_tag;
    logic [2:0]      count;

    qupls_alu_steer #(.DEPTH(DEPTH), .TAGW(TAGW), .instruction_t(logic [31:0])) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_v(in_v), .in_rdy(in_rdy), .in_instr(in_instr), .in_alu0(in_alu0), .in_tag(in_tag),
        .alu0_v(alu0_v), .alu0_rdy(alu0_rdy), .alu0_instr(alu0_instr), .alu0_tag(alu0_tag),
        .alu1_v(alu1_v), .alu1_rdy(alu1_rdy), .alu1_instr(alu1_instr), .alu1_tag(alu1_tag),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            a0;
        logic [TAGW-1:0] tag;
        logic [31:0]     instr;
    } ent_t;

    ent_t q[$];
    int   popped_tags[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Which port (0/1, -1 = none) the oldest and second-oldest queued entries go to
    function automatic void plan(input logic r0, input logic r1, output int hp, output int sp);
        hp = -1;
        sp = -1;
        if (q.size() >= 1) begin
            if (q[0].a0) begin
                if (r0) hp = 0;
            end else if (r1) hp = 1;
            else if (r0) hp = 0;
        end
        if (hp >= 0 && q.size() >= 2) begin
            if (hp == 0 && r1 && !q[1].a0) sp = 1;
            if (hp == 1 && r0) sp = 0;
        end
    endfunction

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        int   hp, sp, sz;
        ent_t z, e0, e1;
        logic v0, v1;
        z = '{a0: 1'b0, tag: '0, instr: '0};
        if (!rst_n) begin
            hp = -1; sp = -1; sz = 0;
        end else begin
            plan(alu0_rdy, alu1_rdy, hp, sp);
            sz = q.size();
        end
        v0 = (hp == 0) || (sp == 0);
        v1 = (hp == 1) || (sp == 1);
        e0 = (hp == 0) ? q[0] : ((sp == 0) ? q[1] : z);
        e1 = (hp == 1) ? q[0] : ((sp == 1) ? q[1] : z);
        chk("count", count, sz);
        chk("in_rdy", in_rdy, (sz < DEPTH));
        chk("alu0_v", alu0_v, v0);
        chk("alu1_v", alu1_v, v1);
        chk("alu0_tag", alu0_tag, e0.tag);
        chk("alu1_tag", alu1_tag, e1.tag);
        chk("alu0_instr", alu0_instr, e0.instr);
        chk("alu1_instr", alu1_instr, e1.instr);
    end

    // Reference model state update
    always @(posedge clk or negedge rst_n) begin
        int hp, sp, n;
        bit acc;
        if (!rst_n) begin
            q.delete();
        end else begin
            plan(alu0_rdy, alu1_rdy, hp, sp);
            acc = in_v && (q.size() < DEPTH);
            if (flush) begin
                q.delete();
            end else begin
                n = (hp >= 0 ? 1 : 0) + (sp >= 0 ? 1 : 0);
                repeat (n) begin
                    popped_tags.push_back(int'(q[0].tag));
                    void'(q.pop_front());
                end
                if (acc) q.push_back('{a0: in_alu0, tag: in_tag, instr: in_instr});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic a0, input int tag);
        in_v     = 1'b1;
        in_alu0  = a0;
        in_tag   = TAGW'(tag);
        in_instr = $urandom;
    endtask

    initial begin
        int sent, cyc;
        bit accepted;

        // Reset held for three cycles with both ALUs ready: nothing may dispatch
        alu0_rdy = 1'b1;
        alu1_rdy = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("idle_count", count, 0);
        chk("idle_in_rdy", in_rdy, 1);
        chk("idle_v", {alu0_v, alu1_v}, 0);

        // MUL tag 3 then ADD tag 4, released together
        step();
        alu0_rdy = 1'b0; alu1_rdy = 1'b0;
        offer(1'b1, 3); step();
        offer(1'b0, 4); step();
        in_v = 1'b0; alu0_rdy = 1'b1; alu1_rdy = 1'b1;
        @(negedge clk);
        chk("pair_alu0_v", alu0_v, 1);
        chk("pair_alu0_tag", alu0_tag, 3);
        chk("pair_alu1_v", alu1_v, 1);
        chk("pair_alu1_tag", alu1_tag, 4);
        step();
        @(negedge clk);
        chk("pair_count_after", count, 0);

        // Two DIVs: both go to ALU #0 in consecutive cycles
        step();
        alu0_rdy = 1'b0; alu1_rdy = 1'b0;
        offer(1'b1, 1); step();
        offer(1'b1, 2); step();
        in_v = 1'b0; alu0_rdy = 1'b1; alu1_rdy = 1'b1;
        @(negedge clk);
        chk("div1_alu0_tag", {alu0_v, alu0_tag}, {1'b1, 5'd1});
        chk("div1_alu1_v", alu1_v, 0);
        step();
        @(negedge clk);
        chk("div2_alu0_tag", {alu0_v, alu0_tag}, {1'b1, 5'd2});
        chk("div2_alu1_v", alu1_v, 0);
        step();
        @(negedge clk);
        chk("div_count_after", count, 0);

        // Fill to DEPTH with both ALUs stalled, then drain through ALU #1
        step();
        alu0_rdy = 1'b0; alu1_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offer(1'b0, 10 + i);
            step();
        end
        offer(1'b0, 14);
        @(negedge clk);
        chk("full_count", count, 4);
        chk("full_in_rdy", in_rdy, 0);
        step();
        in_v = 1'b0; alu1_rdy = 1'b1;
        @(negedge clk);
        chk("drain1_alu1", {alu1_v, alu1_tag}, {1'b1, 5'd10});
        chk("drain1_alu0_v", alu0_v, 0);
        chk("drain1_in_rdy", in_rdy, 0);
        step();
        @(negedge clk);
        chk("drain2_count", count, 3);
        chk("drain2_in_rdy", in_rdy, 1);
        chk("drain2_alu1", {alu1_v, alu1_tag}, {1'b1, 5'd11});
        repeat (3) step();
        @(negedge clk);
        chk("drain_empty", count, 0);

        // Wrap: ten ADDs through random ready stalls must leave in order
        step();
        popped_tags.delete();
        sent = 0;
        cyc  = 0;
        while ((sent < 10 || q.size() != 0) && cyc < 300) begin
            if (sent < 10) offer(1'b0, sent);
            else in_v = 1'b0;
            alu0_rdy = 1'($urandom_range(0, 1));
            alu1_rdy = 1'($urandom_range(0, 1));
            accepted = in_v && in_rdy;
            step();
            if (accepted) sent++;
            cyc++;
        end
        in_v = 1'b0;
        chk("wrap_timeout", (cyc < 300), 1);
        chk("wrap_ntags", popped_tags.size(), 10);
        for (int i = 0; i < 10 && i < popped_tags.size(); i++)
            chk("wrap_order", popped_tags[i], i);

        // Flush at count 3 while a push and dispatches are offered
        alu0_rdy = 1'b0; alu1_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b0, 20 + i);
            step();
        end
        offer(1'b0, 23);
        flush = 1'b1; alu0_rdy = 1'b1; alu1_rdy = 1'b1;
        @(negedge clk);
        chk("flush_cyc_count", count, 3);
        chk("flush_cyc_alu1", {alu1_v, alu1_tag}, {1'b1, 5'd20});
        chk("flush_cyc_alu0", {alu0_v, alu0_tag}, {1'b1, 5'd21});
        step();
        flush = 1'b0; in_v = 1'b0;
        @(negedge clk);
        chk("flush_count", count, 0);
        chk("flush_v", {alu0_v, alu1_v}, 0);
        step();
        offer(1'b0, 24);
        step();
        in_v = 1'b0;
        @(negedge clk);
        chk("post_flush_alu1", {alu1_v, alu1_tag}, {1'b1, 5'd24});
        chk("post_flush_alu0_v", alu0_v, 0);
        step();

        // Random traffic with occasional flushes and one mid-stream reset
        for (int i = 0; i < 1500; i++) begin
            in_v     = 1'($urandom_range(0, 1));
            in_alu0  = 1'($urandom_range(0, 2) == 0);
            in_tag   = TAGW'($urandom);
            in_instr = $urandom;
            alu0_rdy = 1'($urandom_range(0, 3) != 0);
            alu1_rdy = 1'($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 31) == 0);
            if (i == 700) rst_n = 1'b0;
            if (i == 702) rst_n = 1'b1;
            step();
        end
        in_v = 1'b0; flush = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
